eth_tx_framer: RTL

//  RMII transmit framer directly downstream of the pixel packetizer in ether_export. Consumes the packetizer's

---
 rtl/eth_tx_framer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_framer.sv
// RMII transmit framer: preamble/SFD, payload, zero padding, CRC-32 FCS and
// inter-packet gap, one dibit per clock with every output registered.
module eth_tx_framer #(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IPG_BYTES       = 12
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] s_data_in,
  input  logic       s_valid_in,
  input  logic       s_last_in,
  output logic       s_ready_out,
  output logic       eth_txen,
  output logic [1:0] eth_txd,
  output logic       busy_out,
  output logic       underrun_out,
  output logic       frame_done_out
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_PAY, ST_PAD, ST_FCS, ST_IPG
  } state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  IPG_LAST = 8'(IPG_BYTES - 1);
  localparam logic [15:0] MIN_B    = 16'(MIN_FRAME_BYTES);

  state_t      r_state, w_nxt_state;
  logic [1:0]  r_d, w_nxt_d;
  logic [7:0]  r_bcnt, w_nxt_bcnt;
  logic [15:0] r_pcnt, w_nxt_pcnt;
  logic [31:0] r_crc, w_nxt_crc;
  logic [7:0]  r_sh, w_nxt_sh;
  logic        r_last, r_bad;
  logic        w_accept, w_underrun, w_start, w_nxt_last, w_nxt_bad;
  logic [1:0]  w_nxt_txd;
  logic        w_nxt_ready, w_nxt_txen, w_nxt_done;

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state, byte counter and handshake decisions at byte boundaries.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_d     = r_d + 2'd1;
    w_nxt_bcnt  = r_bcnt;
    w_accept    = 1'b0;
    w_underrun  = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt_d = 2'd0;
        if (s_valid_in) begin
          w_nxt_state = ST_PRE;
          w_start     = 1'b1;
          w_nxt_bcnt  = 8'd0;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (r_d == 2'd3) begin
          if (r_bcnt == PRE_LAST) begin
            w_nxt_state = ST_SFD;
            w_nxt_bcnt  = 8'd0;
          end else begin
            w_nxt_bcnt = r_bcnt + 8'd1;
          end
        end else begin
          w_nxt_bcnt = r_bcnt;
        end
      end
      ST_SFD, ST_PAY: begin
        if (r_d == 2'd3) begin
          if (r_state == ST_PAY && r_last) begin
            w_nxt_state = (r_pcnt < MIN_B) ? ST_PAD : ST_FCS;
            w_nxt_bcnt  = 8'd0;
          end else if (s_valid_in) begin
            w_accept    = 1'b1;
            w_nxt_state = ST_PAY;
          end else begin
            w_underrun  = 1'b1;
            w_nxt_state = ST_FCS;
            w_nxt_bcnt  = 8'd0;
          end
        end else begin
          w_nxt_state = r_state;
        end
      end
      ST_PAD: begin
        if (r_d == 2'd3 && r_pcnt >= MIN_B) begin
          w_nxt_state = ST_FCS;
          w_nxt_bcnt  = 8'd0;
        end else begin
          w_nxt_state = ST_PAD;
        end
      end
      ST_FCS: begin
        if (r_d == 2'd3) begin
          if (r_bcnt == 8'd3) begin
            w_nxt_state = ST_IPG;
            w_nxt_bcnt  = 8'd0;
          end else begin
            w_nxt_bcnt = r_bcnt + 8'd1;
          end
        end else begin
          w_nxt_bcnt = r_bcnt;
        end
      end
      ST_IPG: begin
        // A pending request at the end of the gap starts the preamble directly,
        // so back-to-back frames are separated by exactly IPG_BYTES*4 idle clocks.
        if (r_d == 2'd3 && r_bcnt == IPG_LAST) begin
          w_nxt_bcnt = 8'd0;
          if (s_valid_in) begin
            w_nxt_state = ST_PRE;
            w_start     = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else if (r_d == 2'd3) begin
          w_nxt_bcnt = r_bcnt + 8'd1;
        end else begin
          w_nxt_bcnt = r_bcnt;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_d     = 2'd0;
      end
    endcase
  end

  // Wire dibit, CRC, shift register and output strobes for the next cycle.
  always_comb begin
    w_nxt_txd  = 2'b00;
    w_nxt_sh   = r_sh;
    w_nxt_crc  = r_crc;
    w_nxt_last = w_accept ? s_last_in : r_last;
    w_nxt_bad  = w_start ? 1'b0 : (r_bad | w_underrun);
    w_nxt_pcnt = w_start ? 16'd0 : r_pcnt;
    case (w_nxt_state)
      ST_PRE: begin
        w_nxt_txd = 2'b01;
        w_nxt_crc = 32'hFFFF_FFFF;
      end
      ST_SFD: w_nxt_txd = (w_nxt_d == 2'd3) ? 2'b11 : 2'b01;
      ST_PAY: begin
        if (w_accept) begin
          w_nxt_txd = s_data_in[1:0];
          w_nxt_sh  = {2'b00, s_data_in[7:2]};
        end else begin
          w_nxt_txd = r_sh[1:0];
          w_nxt_sh  = r_sh >> 2;
        end
        w_nxt_crc = crc_dibit(r_crc, w_nxt_txd);
      end
      ST_PAD: w_nxt_crc = crc_dibit(r_crc, 2'b00);
      ST_FCS: begin
        w_nxt_txd = w_nxt_bad ? r_crc[1:0] : ~r_crc[1:0];
        w_nxt_crc = r_crc >> 2;
      end
      default: w_nxt_txd = 2'b00;
    endcase
    if ((w_nxt_state == ST_PAY || w_nxt_state == ST_PAD) && w_nxt_d == 2'd0 && r_pcnt < MIN_B) begin
      w_nxt_pcnt = r_pcnt + 16'd1;
    end else begin
      w_nxt_pcnt = w_nxt_pcnt;
    end
    w_nxt_txen  = (w_nxt_state != ST_IDLE) && (w_nxt_state != ST_IPG);
    w_nxt_ready = (w_nxt_d == 2'd3) &&
                  ((w_nxt_state == ST_SFD) || (w_nxt_state == ST_PAY && !w_nxt_last));
    w_nxt_done  = (w_nxt_state == ST_FCS) && (w_nxt_d == 2'd3) && (w_nxt_bcnt == 8'd3);
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= ST_IDLE;
      r_d            <= 2'd0;
      r_bcnt         <= 8'd0;
      r_pcnt         <= 16'd0;
      r_crc          <= 32'hFFFF_FFFF;
      r_sh           <= 8'd0;
      r_last         <= 1'b0;
      r_bad          <= 1'b0;
      s_ready_out    <= 1'b0;
      eth_txen       <= 1'b0;
      eth_txd        <= 2'b00;
      busy_out       <= 1'b0;
      underrun_out   <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_d            <= w_nxt_d;
      r_bcnt         <= w_nxt_bcnt;
      r_pcnt         <= w_nxt_pcnt;
      r_crc          <= w_nxt_crc;
      r_sh           <= w_nxt_sh;
      r_last         <= w_nxt_last;
      r_bad          <= w_nxt_bad;
      s_ready_out    <= w_nxt_ready;
      eth_txen       <= w_nxt_txen;
      eth_txd        <= w_nxt_txd;
      busy_out       <= (w_nxt_state != ST_IDLE);
      underrun_out   <= w_underrun;
      frame_done_out <= w_nxt_done;
    end
  end

endmodule
